// File: rtl/counter_job_sequencer_if.sv
// Job/counter/completion signal bundle for counter_job_sequencer.
// slave modport: the sequencer itself; master modport: requesters, counter and completion sink.
interface counter_job_sequencer_if #(
  parameter int unsigned WIDTH = 32
);
  logic             req0_valid;
  logic [WIDTH-1:0] req0_load;
  logic             req0_ready;
  logic             req1_valid;
  logic [WIDTH-1:0] req1_load;
  logic             req1_ready;
  logic [WIDTH-1:0] cnt_in;
  logic             cnt_latch;
  logic             cnt_dec;
  logic             cnt_zero;
  logic             done_valid;
  logic             done_id;
  logic [WIDTH-1:0] done_cycles;
  logic             done_err;
  logic             busy;

  modport slave (
    input  req0_valid, req0_load, req1_valid, req1_load, cnt_zero,
    output req0_ready, req1_ready, cnt_in, cnt_latch, cnt_dec,
           done_valid, done_id, done_cycles, done_err, busy
  );

  modport master (
    output req0_valid, req0_load, req1_valid, req1_load, cnt_zero,
    input  req0_ready, req1_ready, cnt_in, cnt_latch, cnt_dec,
           done_valid, done_id, done_cycles, done_err, busy
  );
endinterface

// File: rtl/counter_job_sequencer.sv
// counter_job_sequencer: round-robin arbiter for two count-job requesters that
// loads the shared down-counter, decrements it to zero and reports the number
// of decrement cycles issued.
// Optional watchdog: define CNT_SEQ_TIMEOUT_EN to abort RUN after TMO_CYCLES
// decrements (done_err=1); otherwise done_err is tied low.
module counter_job_sequencer #(
  parameter int unsigned WIDTH      = 32,
  parameter int unsigned TMO_CYCLES = 4096
) (
  input logic                    clock,
  input logic                    reset,
  counter_job_sequencer_if.slave bus
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_LOAD,
    S_SETTLE,
    S_RUN,
    S_DONE
  } state_t;

  state_t           state;
  logic             rr_ptr;
  logic             job_id;
  logic [WIDTH-1:0] cycles;
  logic             grant1;
  logic             accept;
  logic             tmo_hit;
  logic             dec;

  // Arbitration: a lone valid wins, a tie goes to the round-robin pointer.
  always_comb begin
    grant1 = bus.req1_valid & (~bus.req0_valid | rr_ptr);
    accept = (state == S_IDLE) & (grant1 ? bus.req1_valid : bus.req0_valid);
  end

  // Ready is only offered in IDLE, and only to the granted requester.
  always_comb begin
    bus.req0_ready = (state == S_IDLE) & ~grant1;
    bus.req1_ready = (state == S_IDLE) & grant1;
  end

`ifdef CNT_SEQ_TIMEOUT_EN
  localparam logic [WIDTH-1:0] TMO_LIMIT = WIDTH'(TMO_CYCLES);

  // Watchdog fires once TMO_LIMIT decrements have been issued without reaching zero.
  always_comb tmo_hit = (state == S_RUN) & ~bus.cnt_zero & (cycles == TMO_LIMIT);
`else
  // No watchdog in this build: RUN waits on cnt_zero indefinitely.
  always_comb tmo_hit = 1'b0;

  // Abort flag never raised without the watchdog.
  always_comb bus.done_err = 1'b0;
`endif

  // dec must follow cnt_zero in the same cycle so the counter never wraps,
  // hence it is decoded from state rather than registered.
  always_comb begin
    dec         = (state == S_RUN) & ~bus.cnt_zero & ~tmo_hit;
    bus.cnt_dec = dec;
    bus.busy    = (state != S_IDLE);
  end

  // Sequencer FSM with registered latch/in/done outputs.
  always_ff @(posedge clock) begin
    if (reset) begin
      state           <= S_IDLE;
      rr_ptr          <= 1'b0;
      job_id          <= 1'b0;
      cycles          <= '0;
      bus.cnt_in      <= '0;
      bus.cnt_latch   <= 1'b0;
      bus.done_valid  <= 1'b0;
      bus.done_id     <= 1'b0;
      bus.done_cycles <= '0;
`ifdef CNT_SEQ_TIMEOUT_EN
      bus.done_err    <= 1'b0;
`endif
    end else begin
      bus.done_valid <= 1'b0;
      case (state)
        S_IDLE: begin
          if (accept) begin
            job_id        <= grant1;
            rr_ptr        <= ~grant1;
            cycles        <= '0;
            bus.cnt_in    <= grant1 ? bus.req1_load : bus.req0_load;
            bus.cnt_latch <= 1'b1;
            state         <= S_LOAD;
          end
        end
        S_LOAD: begin
          bus.cnt_latch <= 1'b0;
          state         <= S_SETTLE;
        end
        S_SETTLE: begin
          state <= S_RUN;
        end
        S_RUN: begin
          if (dec && (cycles != '1)) begin
            cycles <= cycles + 1'b1;
          end
          if (bus.cnt_zero || tmo_hit) begin
            bus.done_valid  <= 1'b1;
            bus.done_id     <= job_id;
            bus.done_cycles <= cycles;
`ifdef CNT_SEQ_TIMEOUT_EN
            bus.done_err    <= tmo_hit;
`endif
            state           <= S_DONE;
          end
        end
        S_DONE: begin
          state <= S_IDLE;
        end
        default: begin
          state <= S_IDLE;
        end
      endcase
    end
  end

endmodule
